// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 steering cell: select encodings and default data width.
package mux_pkg;

    localparam logic MUX_SEL_A         = 1'b0;
    localparam logic MUX_SEL_B         = 1'b1;
    localparam int   MUX_WIDTH_DEFAULT = 1;

endpackage : mux_pkg

// File: rtl/mux_2to1_core.sv
// Combinational WIDTH-bit 2:1 select; an unknown select only blurs bits where a and b differ.
module mux_2to1_core
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y_c
);

    // The conditional operator merges a and b bitwise when s is unknown.
    assign y_c = (s == MUX_SEL_B) ? b : a;

endmodule : mux_2to1_core

// File: rtl/mux_2to1.sv
// Leaf steering cell: 2:1 select with either a registered output (1-cycle latency)
// or a reset-gated combinational output, both cleared asynchronously by active-low rst.
module mux_2to1
    import mux_pkg::*;
#(
    parameter int WIDTH   = MUX_WIDTH_DEFAULT,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_c_s;

    mux_2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (a),
        .b   (b),
        .s   (s),
        .y_c (y_c_s)
    );

    if (WIDTH < 1) begin : g_width_chk
        $error("mux_2to1: WIDTH must be at least 1");
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] y_r;

        // Output register; rst clears it without a clock and holds it while low.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                y_r <= {WIDTH{1'b0}};
            end else begin
                y_r <= y_c_s;
            end
        end

        assign y = y_r;
    end else begin : g_comb
        logic [WIDTH-1:0] y_gated_s;
        logic             unused_clk_s;

        // No storage in this variant; the clock is intentionally left idle.
        assign unused_clk_s = clk;

        // Reset gating of the combinational select.
        always_comb begin
            y_gated_s = {WIDTH{1'b0}};
            if (rst) begin
                y_gated_s = y_c_s;
            end else begin
                y_gated_s = {WIDTH{1'b0}};
            end
        end

        assign y = y_gated_s;
    end

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: registered 1-bit and 8-bit variants plus the combinational variant.
module tb_mux_2to1;

    logic       clk;
    int         total;
    int         bad;

    logic       rst1, a1, b1, s1;
    logic       y1;
    logic       rst8, s8;
    logic [7:0] a8, b8, y8;
    logic       rst0, a0, b0, s0;
    logic       y0;

    mux_2to1 #(.WIDTH(1), .REG_OUT(1'b1)) u_reg1 (
        .clk (clk), .rst (rst1), .a (a1), .b (b1), .s (s1), .y (y1)
    );

    mux_2to1 #(.WIDTH(8), .REG_OUT(1'b1)) u_reg8 (
        .clk (clk), .rst (rst8), .a (a8), .b (b8), .s (s8), .y (y8)
    );

    mux_2to1 #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
        .clk (clk), .rst (rst0), .a (a0), .b (b0), .s (s0), .y (y0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Start released, then assert every reset so a real falling edge occurs.
        rst1 = 1'b1; a1 = 1'b1; b1 = 1'b0; s1 = 1'b1;
        rst8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0;
        rst0 = 1'b1; a0 = 1'b1; b0 = 1'b0; s0 = 1'b0;
        #1;
        rst1 = 1'b0;
        rst8 = 1'b0;
        #1;
        check("rst_hold_t0", {7'd0, y1}, 8'h00);
        check("rst8_hold_t0", y8, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_hold_edge%0d", i), {7'd0, y1}, 8'h00);
        end

        // Release between edges; y must wait for the next edge.
        rst1 = 1'b1;
        #1;
        check("pre_edge_hold", {7'd0, y1}, 8'h00);
        tick();
        check("sel_b_0", {7'd0, y1}, 8'h00);

        s1 = 1'b0;
        #1;
        check("mid_cycle_stable", {7'd0, y1}, 8'h00);
        tick();
        check("sel_a_1", {7'd0, y1}, 8'h01);

        a1 = 1'b0; b1 = 1'b1; s1 = 1'b1;
        #1;
        check("latency_hold_1", {7'd0, y1}, 8'h01);
        tick();
        check("sel_b_1", {7'd0, y1}, 8'h01);

        a1 = 1'b0; b1 = 1'b1; s1 = 1'b0;
        tick();
        check("sel_a_0", {7'd0, y1}, 8'h00);

        // Release exactly on a clock edge: that edge still sees reset.
        s1 = 1'b1;
        tick();
        check("pre_rel_load", {7'd0, y1}, 8'h01);
        rst1 = 1'b0;
        #1;
        check("async_clear_1", {7'd0, y1}, 8'h00);
        a1 = 1'b1; s1 = 1'b0;
        @(posedge clk);
        rst1 <= 1'b1;
        #1;
        check("rel_on_edge", {7'd0, y1}, 8'h00);
        tick();
        check("rel_next_edge", {7'd0, y1}, 8'h01);

        // 8-bit path.
        rst8 = 1'b1;
        a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0;
        tick();
        check("w8_sel_a", y8, 8'hA5);
        s8 = 1'b1;
        tick();
        check("w8_sel_b", y8, 8'h3C);
        a8 = 8'h0F; b8 = 8'hF0;
        #1;
        check("w8_mid_stable", y8, 8'h3C);
        #1;
        rst8 = 1'b0;
        #1;
        check("w8_async_clear", y8, 8'h00);
        tick();
        check("w8_rst_held", y8, 8'h00);
        rst8 = 1'b1;
        tick();
        check("w8_reload_b", y8, 8'hF0);
        s8 = 1'b0;
        tick();
        check("w8_reload_a", y8, 8'h0F);

        // Combinational variant.
        rst0 = 1'b1; a0 = 1'b1; b0 = 1'b0; s0 = 1'b0;
        #1;
        check("comb_sel_a", {7'd0, y0}, 8'h01);
        s0 = 1'b1;
        #1;
        check("comb_sel_b", {7'd0, y0}, 8'h00);
        s0 = 1'b0;
        #1;
        check("comb_sel_a_again", {7'd0, y0}, 8'h01);
        rst0 = 1'b0;
        #1;
        check("comb_rst_gate", {7'd0, y0}, 8'h00);
        s0 = 1'b1; b0 = 1'b1;
        #1;
        check("comb_rst_gate_b", {7'd0, y0}, 8'h00);
        rst0 = 1'b1;
        #1;
        check("comb_rel", {7'd0, y0}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_2to1
